// File: rtl/dcm_rst_ctrl.sv
// DCM reset sequencer: pulses the DCM reset, waits for lock, requires stable
// lock for a hold period, then releases the system reset. Lock loss or a soft
// request in RUN restarts the sequence; lock failures are counted.
module dcm_rst_ctrl #(
  parameter int unsigned RST_PULSE_CYC = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned HOLD_CYC      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dcm_locked,
  input  logic       soft_rst_req,
  output logic       dcm_rst,
  output logic       sys_reset,
  output logic       clk_ok,
  output logic [7:0] err_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 8;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_DCM_RST,
    S_WAIT_LOCK,
    S_HOLD,
    S_RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_inc;
  logic             lock_meta;
  logic             lock_s;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= dcm_locked;
      lock_s    <= lock_meta;
    end
  end

  // Next-state and failure-event decode
  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    case (state_q)
      S_DCM_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_HOLD;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_DCM_RST;
          err_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_DCM_RST;
          err_inc = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Lock loss wins over a simultaneous soft request
        if (!lock_s) begin
          state_d = S_DCM_RST;
          err_inc = 1'b1;
        end else if (soft_rst_req) begin
          state_d = S_DCM_RST;
        end
      end
      default: state_d = S_DCM_RST;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output is a flop that tracks the state-register decode exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_DCM_RST;
      dcm_rst   <= 1'b1;
      sys_reset <= 1'b1;
      clk_ok    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcm_rst   <= (state_d == S_DCM_RST);
      sys_reset <= (state_d != S_RUN);
      clk_ok    <= (state_d == S_RUN);
    end
  end

  // Shared cycle counter, cleared whenever the state changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Saturating lock-failure counter, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: doc/dcm_rst_ctrl.md
DCM_RST_CTRL -- requirements
Module: dcm_rst_ctrl

Interface
REQ-001 Parameter RST_PULSE_CYC, default 4: number of clk cycles dcm_rst is held high per DCM reset pulse; legal range 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 1024: number of clk cycles to wait for lock before retrying; legal range 1..65535.
REQ-003 Parameter HOLD_CYC, default 16: number of cycles of continuous synchronized lock required before system reset release; legal range 1..65535.
REQ-004 Port clk, input, 1 bit: free-running reference clock, the same source that drives the DCM input; this is the only clock.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port dcm_locked, input, 1 bit: DCM lock indication, asynchronous to clk.
REQ-007 Port soft_rst_req, input, 1 bit: single-cycle request to re-run the full clock/reset sequence.
REQ-008 Port dcm_rst, output, 1 bit: reset to the DCM, active-high.
REQ-009 Port sys_reset, output, 1 bit: system reset to all downstream logic, active-high.
REQ-010 Port clk_ok, output, 1 bit: high only while in RUN.
REQ-011 Port err_cnt, output, 8 bits: saturating count of lock failures.

Function
REQ-012 dcm_locked SHALL pass through a 2-flop synchronizer (lock_s) before any use; lock_s latency is 2 edges.
REQ-013 The FSM SHALL have four states: DCM_RST, WAIT_LOCK, HOLD, RUN.
REQ-014 One shared 16-bit cycle counter cnt SHALL clear to 0 on every state transition and increment by 1 on every other edge.
REQ-015 DCM_RST SHALL go to WAIT_LOCK at the edge where cnt == RST_PULSE_CYC-1.
REQ-016 WAIT_LOCK SHALL transition as follows, checked in this order:
- lock_s=1 -> HOLD;
- otherwise, cnt == LOCK_TIMEOUT-1 -> DCM_RST, with err_cnt incremented.
REQ-017 HOLD SHALL transition as follows, checked in this order:
- lock_s=0 -> DCM_RST, with err_cnt incremented;
- otherwise, cnt == HOLD_CYC-1 -> RUN.
REQ-018 RUN SHALL transition as follows, checked in this order:
- lock_s=0 -> DCM_RST, with err_cnt incremented (lock loss takes priority over a simultaneous soft_rst_req);
- soft_rst_req=1 -> DCM_RST, with err_cnt unchanged.
REQ-019 soft_rst_req SHALL be ignored in every state except RUN.
REQ-020 Outputs SHALL be decoded from the state register only, so they are glitch-free and carry no combinational path from any input:
- dcm_rst = (state == DCM_RST);
- sys_reset = (state != RUN);
- clk_ok = (state == RUN).
REQ-021 err_cnt SHALL saturate at 255; an increment at 255 SHALL leave it at 255; err_cnt SHALL clear only on reset.

Reset
REQ-022 While reset=1, without waiting for a clock edge:
- state = DCM_RST;
- cnt = 0 and synchronizer flops = 0;
- dcm_rst = 1, sys_reset = 1, clk_ok = 0, err_cnt = 0.
REQ-023 Reset asserted mid-operation in any state SHALL restart the sequence from DCM_RST at the first edge after release.

Verification
Scenario parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT=16, HOLD_CYC=8. E1 denotes the first rising clk edge after reset release.
REQ-024 Lock-up: dcm_locked=1 before E5 -> dcm_rst=1 through E4 and 0 after E4; state = HOLD after E7; sys_reset=0 and clk_ok=1 after E15; err_cnt=0.
REQ-025 Timeout: dcm_locked held 0 -> WAIT_LOCK entered at E4; at E20 the FSM returns to DCM_RST, dcm_rst=1, err_cnt=1; the pattern repeats every 20 cycles (err_cnt=2 at E40); sys_reset stays 1 throughout.
REQ-026 Lock loss: in RUN, drive dcm_locked=0 for 3 cycles -> within 3 edges sys_reset=1, clk_ok=0, dcm_rst=1, err_cnt incremented by exactly 1; restoring lock replays the full sequence to RUN.
REQ-027 Soft reset: in RUN, pulse soft_rst_req for 1 cycle -> state = DCM_RST after the next edge, dcm_rst high for 4 cycles, err_cnt unchanged; if the same pulse coincides with lock_s=0, err_cnt is incremented.
REQ-028 Async reset: assert reset between edges while in HOLD with err_cnt=3 -> dcm_rst=1, sys_reset=1, clk_ok=0, err_cnt=0 with no clk edge; the post-release sequence matches REQ-024.
REQ-029 Saturation: force 260 consecutive timeouts -> err_cnt reaches 255 and holds at 255; no wrap to 0.
